button_debounce_leds: RTL and testbench

// - Multi-channel successor to the direct switch-to-LED path: synchronises, debounces and edge-detects
//   NUM_CH raw push-buttons, then drives one LED per button in a per-channel mode.
// - Each channel runs in direct mode (LED follows the debounced button) or toggle mode (each press flips the LED).
// - Sits between board button pins and LED pins.
// - Debounced levels and press/release pulses are exported for downstream control logic.

---
 rtl/button_debounce_leds.sv | 123 ++++++++++++
 tb/tb_button_debounce_leds.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_leds.sv
// Multi-channel button synchroniser, debouncer and edge detector driving one LED per channel (direct or toggle).
// Optional `define LONG_PRESS_EN adds a per-channel hold counter and the long_pulse output.
module button_debounce_leds #(
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned BTN_ACTIVE_LOW  = 1,
  parameter int unsigned LED_ACTIVE_LOW  = 1,
  parameter int unsigned LONG_CYCLES     = 27000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] btn_raw,
  input  logic [NUM_CH-1:0] mode,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse,
`ifdef LONG_PRESS_EN
  output logic [NUM_CH-1:0] long_pulse,
`endif
  output logic [NUM_CH-1:0] led
);

  localparam int unsigned CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic        REL_PIN  = (BTN_ACTIVE_LOW != 0);
  localparam logic        LED_OFF  = (LED_ACTIVE_LOW != 0);

  if (NUM_CH < 1 || DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_param_check
    $error("button_debounce_leds: illegal parameter value");
  end

  logic [NUM_CH-1:0] sync1, sync2, sample;
  logic [NUM_CH-1:0] latch, level_d, press_d, release_d, latch_d, led_d;
  logic [CW-1:0]     cnt   [NUM_CH];
  logic [CW-1:0]     cnt_d [NUM_CH];

  // Two-flop synchroniser; resets to the released pin level so no edge is seen on release of rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= {NUM_CH{REL_PIN}};
      sync2 <= {NUM_CH{REL_PIN}};
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign sample = (BTN_ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // Debounce, edge detection, toggle latch and LED selection
  always_comb begin
    level_d   = btn_level;
    press_d   = '0;
    release_d = '0;
    led_d     = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      cnt_d[ch] = cnt[ch];
      if (sample[ch] == btn_level[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt[ch] == CNT_LAST) begin
        cnt_d[ch]     = '0;
        level_d[ch]   = sample[ch];
        press_d[ch]   = sample[ch];
        release_d[ch] = ~sample[ch];
      end else begin
        cnt_d[ch] = CW'(cnt[ch] + 1'b1);
      end
      led_d[ch] = (mode[ch] ? latch[ch] : btn_level[ch]) ^ LED_OFF;
    end
    latch_d = latch ^ press_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) cnt[ch] <= '0;
      btn_level     <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      latch         <= '0;
      led           <= {NUM_CH{LED_OFF}};
    end else begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) cnt[ch] <= cnt_d[ch];
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      latch         <= latch_d;
      led           <= led_d;
    end
  end

`ifdef LONG_PRESS_EN
  localparam int unsigned HW        = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0]     hold   [NUM_CH];
  logic [HW-1:0]     hold_d [NUM_CH];
  logic [NUM_CH-1:0] long_d;

  // Hold counter saturates so the long pulse fires once per press; a simultaneous release suppresses it
  always_comb begin
    long_d = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      hold_d[ch] = '0;
      if (btn_level[ch]) begin
        hold_d[ch] = (hold[ch] == HOLD_MAX) ? hold[ch] : HW'(hold[ch] + 1'b1);
        long_d[ch] = (hold[ch] == HOLD_LAST) && !release_d[ch];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) hold[ch] <= '0;
      long_pulse <= '0;
    end else begin
      for (int unsigned ch = 0; ch < NUM_CH; ch++) hold[ch] <= hold_d[ch];
      long_pulse <= long_d;
    end
  end
`endif

endmodule

// File: tb/tb_button_debounce_leds.sv
// Self-checking bench for button_debounce_leds (NUM_CH=2, DEBOUNCE_CYCLES=8, LONG_CYCLES=32, active-low pins).
// Long-press checks are included when LONG_PRESS_EN is defined.
module tb_button_debounce_leds;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_raw;
  logic [1:0] mode;
  logic [1:0] btn_level, press_pulse, release_pulse, led;
`ifdef LONG_PRESS_EN
  logic [1:0] long_pulse;
`endif

  int total = 0;
  int bad   = 0;

  button_debounce_leds #(
    .NUM_CH(2), .DEBOUNCE_CYCLES(8), .BTN_ACTIVE_LOW(1), .LED_ACTIVE_LOW(1), .LONG_CYCLES(32)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .mode(mode),
    .btn_level(btn_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
`ifdef LONG_PRESS_EN
    .long_pulse(long_pulse),
`endif
    .led(led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] btn;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] led;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int n, at, both, partial, nrel;

    // Clean press then release of ch0, edge E = row 0
    for (int i = 0; i < NV; i++) begin
      tbl[i].btn = (i <= 10) ? 2'b10 : 2'b11;
      tbl[i].lvl = 2'b00;
      tbl[i].prs = 2'b00;
      tbl[i].rel = 2'b00;
      tbl[i].led = 2'b11;
    end
    for (int i = 9; i < 20; i++)  tbl[i].lvl = 2'b01;
    for (int i = 10; i <= 20; i++) tbl[i].led = 2'b10;
    tbl[9].prs  = 2'b01;
    tbl[20].rel = 2'b01;

    rst = 1'b1; btn_raw = 2'b11; mode = 2'b00;
    #2;
    chk("reset_assert", {btn_level, press_pulse, release_pulse, led}, 8'b00_00_00_11);
    repeat (3) tick();
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if ({btn_level, press_pulse, release_pulse, led} != 8'b00_00_00_11) n++;
    end
    chk("reset_quiet_50", n, 0);

    for (int i = 0; i < NV; i++) begin
      btn_raw = tbl[i].btn;
      tick();
      chk($sformatf("vec%0d_level", i), btn_level, tbl[i].lvl);
      chk($sformatf("vec%0d_press", i), press_pulse, tbl[i].prs);
      chk($sformatf("vec%0d_release", i), release_pulse, tbl[i].rel);
      chk($sformatf("vec%0d_led", i), led, tbl[i].led);
    end

    // Bounce on ch0: 3-cycle runs never reach the threshold
    n = 0;
    for (int c = 0; c < 40; c++) begin
      btn_raw[0] = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      if (press_pulse[0] || release_pulse[0]) n++;
    end
    chk("bounce_quiet", n, 0);
    btn_raw[0] = 1'b0;
    n = 0; at = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (press_pulse[0]) begin
        n++;
        if (at < 0) at = k;
      end
    end
    chk("bounce_press_count", n, 1);
    chk("bounce_press_delay", at, 10);
    btn_raw[0] = 1'b1;
    repeat (12) tick();
    chk("bounce_released", btn_level, 2'b00);

    // Toggle mode on ch1
    mode = 2'b10;
    tick();
    chk("toggle_init_led1", led[1], 1);
    for (int p = 0; p < 3; p++) begin
      btn_raw = 2'b01;
      repeat (12) tick();
      chk($sformatf("toggle_press%0d_led1", p), led[1], (p % 2 == 0) ? 0 : 1);
      btn_raw = 2'b11;
      repeat (12) tick();
      chk($sformatf("toggle_release%0d_led1", p), led[1], (p % 2 == 0) ? 0 : 1);
    end
    mode = 2'b00;
    tick();
    chk("mode_switch_led", led, 2'b11);
    chk("mode_switch_no_pulse", {press_pulse, release_pulse}, 0);

    // Simultaneous press on both channels
    btn_raw = 2'b00;
    both = 0; partial = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (press_pulse == 2'b11) both++;
      else if (press_pulse != 2'b00) partial++;
    end
    chk("simul_both", both, 1);
    chk("simul_partial", partial, 0);
    chk("simul_level", btn_level, 2'b11);
    chk("simul_led", led, 2'b00);

    // Asynchronous reset in mid-hold
    #2 rst = 1'b1;
    #1;
    chk("midreset_outputs", {btn_level, press_pulse, release_pulse, led}, 8'b00_00_00_11);
    btn_raw = 2'b11;
    repeat (3) tick();
    rst = 1'b0;
    nrel = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (press_pulse != 2'b00 || release_pulse != 2'b00) nrel++;
    end
    chk("midreset_no_pulses", nrel, 0);
    chk("midreset_level", btn_level, 2'b00);

`ifdef LONG_PRESS_EN
    btn_raw = 2'b10;
    at = -1;
    for (int k = 0; k < 15 && at < 0; k++) begin
      tick();
      if (press_pulse[0]) at = k;
    end
    chk("long_press_seen", (at >= 0) ? 1 : 0, 1);
    n = 0; at = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (long_pulse[0]) begin
        n++;
        if (at < 0) at = k;
      end
    end
    chk("long_count", n, 1);
    chk("long_delay", at, 32);
    chk("long_led_unchanged", led, 2'b10);
    btn_raw = 2'b11;
    repeat (15) tick();
    btn_raw = 2'b10;
    n = 0;
    repeat (20) begin
      tick();
      if (long_pulse != 2'b00) n++;
    end
    btn_raw = 2'b11;
    repeat (15) begin
      tick();
      if (long_pulse != 2'b00) n++;
    end
    chk("short_hold_no_long", n, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
